// File: rtl/defog_pkg.sv
// Shared defog pipeline definitions: widths, constants and the 8-bit clamp helper.
package defog_pkg;

   localparam int unsigned PIX_W           = 8;
   localparam int unsigned T_MIN           = 26;
   localparam int unsigned DIV_STAGES      = 16;
   localparam int unsigned RECOVER_LATENCY = 18;

   // Side-band carried through the divider next to each quotient.
   typedef struct packed {
      logic             sign;
      logic [PIX_W-1:0] atmo;
   } recover_side_t;

   // Clamp a signed intermediate into the unsigned pixel range [0, 255].
   function automatic logic [PIX_W-1:0] saturate_u8(input logic signed [17:0] val);
      if (val < 0) begin
         return '0;
      end else if (val > 18'sd255) begin
         return 8'hFF;
      end else begin
         return val[PIX_W-1:0];
      end
   endfunction

endpackage

// File: rtl/recover_div_pipe.sv
// Fully pipelined restoring divider: 16-bit dividend / 8-bit divisor, one quotient bit per
// stage (MSB first) with a free-form payload travelling alongside. A zero divisor yields a
// zero quotient so flushed (reset) pipeline contents stay at zero.
module recover_div_pipe
   import defog_pkg::*;
#(
   parameter int unsigned PAY_W = 9
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic [15:0]      i_num,
   input  logic [7:0]       i_den,
   input  logic [PAY_W-1:0] i_pay,
   output logic [15:0]      o_quo,
   output logic [PAY_W-1:0] o_pay
);

   localparam int unsigned NS = DIV_STAGES;

   for (genvar g = 0; g < NS; g++) begin : g_stage
      logic [15:0]      r_num;
      logic [15:0]      r_quo;
      logic [7:0]       r_den;
      logic [7:0]       r_rem;
      logic [PAY_W-1:0] r_pay;

      logic [15:0]      w_num_in;
      logic [15:0]      w_quo_in;
      logic [7:0]       w_den_in;
      logic [7:0]       w_rem_in;
      logic [PAY_W-1:0] w_pay_in;
      logic [8:0]       w_shift;
      logic [7:0]       w_diff;
      logic             w_bit;

      if (g == 0) begin : g_src
         assign w_num_in = i_num;
         assign w_quo_in = '0;
         assign w_den_in = i_den;
         assign w_rem_in = '0;
         assign w_pay_in = i_pay;
      end else begin : g_src
         assign w_num_in = g_stage[g-1].r_num;
         assign w_quo_in = g_stage[g-1].r_quo;
         assign w_den_in = g_stage[g-1].r_den;
         assign w_rem_in = g_stage[g-1].r_rem;
         assign w_pay_in = g_stage[g-1].r_pay;
      end

      // Bring down the next dividend bit into the 9-bit partial remainder.
      assign w_shift = {w_rem_in, w_num_in[15]};
      // When the subtraction is taken the true result is < 256, so 8 bits suffice.
      assign w_diff  = w_shift[7:0] - w_den_in;
      assign w_bit   = (w_den_in != 8'd0) && (w_shift >= {1'b0, w_den_in});

      // Stage register: remainder, partial quotient, shifted dividend and side-band.
      always_ff @(posedge clk or negedge nrst) begin
         if (!nrst) begin
            r_num <= '0;
            r_quo <= '0;
            r_den <= '0;
            r_rem <= '0;
            r_pay <= '0;
         end else begin
            r_num <= {w_num_in[14:0], 1'b0};
            r_quo <= {w_quo_in[14:0], w_bit};
            r_den <= w_den_in;
            r_rem <= w_bit ? w_diff : w_shift[7:0];
            r_pay <= w_pay_in;
         end
      end
   end

   assign o_quo = g_stage[NS-1].r_quo;
   assign o_pay = g_stage[NS-1].r_pay;

   // Final remainder and exhausted dividend are not needed downstream.
   logic w_unused;
   assign w_unused = ^{g_stage[NS-1].r_num, g_stage[NS-1].r_rem};

endmodule

// File: rtl/image_recover.sv
// Scene-radiance recovery: J = A + (I - A) * 256 / max(t, T_MIN), clamped to 8 bits.
// Stage 0 registers the operands, 16 divider stages follow, then a saturating output
// register; sync/enable strobes ride an equal-length delay line.
module image_recover #(
   parameter int unsigned T_MIN   = 26,
   parameter int unsigned LATENCY = 18
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic       hsync,
   input  logic       vsync,
   input  logic       en,
   input  logic [7:0] in_data,
   input  logic [7:0] in_trans,
   input  logic [7:0] atmo,
   output logic       o_hsync,
   output logic       o_vsync,
   output logic       o_en,
   output logic [7:0] out_data
);

   import defog_pkg::*;

   // ---------------- frame latch ----------------
   logic       r_vsync_prev;
   logic [7:0] r_atmo;

   // Capture A on vsync rising edge; mid-frame changes wait for the next frame.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_vsync_prev <= 1'b0;
         r_atmo       <= '0;
      end else begin
         r_vsync_prev <= vsync;
         if (vsync && !r_vsync_prev) begin
            r_atmo <= atmo;
         end
      end
   end

   // ---------------- stage 0 ----------------
   logic [7:0]        w_t_eff;
   logic signed [8:0] w_diff;
   logic              w_sign;
   logic [7:0]        w_mag;

   assign w_t_eff = (in_trans < 8'(T_MIN)) ? 8'(T_MIN) : in_trans;
   assign w_diff  = $signed({1'b0, in_data}) - $signed({1'b0, r_atmo});
   assign w_sign  = w_diff[8];
   assign w_mag   = w_sign ? 8'(-w_diff) : w_diff[7:0];

   logic [15:0]   r_num0;
   logic [7:0]    r_t0;
   recover_side_t r_side0;

   // Input register: scaled magnitude, floored transmission and the A snapshot.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_num0  <= '0;
         r_t0    <= '0;
         r_side0 <= '0;
      end else begin
         r_num0       <= {w_mag, 8'd0};
         r_t0         <= w_t_eff;
         r_side0.sign <= w_sign;
         r_side0.atmo <= r_atmo;
      end
   end

   // ---------------- divider ----------------
   logic [15:0]   w_quo;
   recover_side_t w_side;

   recover_div_pipe #(
      .PAY_W ($bits(recover_side_t))
   ) u_div (
      .clk   (clk),
      .nrst  (nrst),
      .i_num (r_num0),
      .i_den (r_t0),
      .i_pay (r_side0),
      .o_quo (w_quo),
      .o_pay (w_side)
   );

   // ---------------- output stage ----------------
   logic signed [17:0] w_j;
   logic [7:0]         r_out;

   // Recombine with A in a wide signed intermediate so neither direction can wrap.
   always_comb begin
      w_j = '0;
      if (w_side.sign) begin
         w_j = $signed({10'd0, w_side.atmo}) - $signed({2'd0, w_quo});
      end else begin
         w_j = $signed({10'd0, w_side.atmo}) + $signed({2'd0, w_quo});
      end
   end

   // Output register with saturation.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_out <= '0;
      end else begin
         r_out <= saturate_u8(w_j);
      end
   end

   assign out_data = r_out;

   // ---------------- strobe delay line ----------------
   logic [2:0] r_sync [LATENCY];

   // Delay {hsync, vsync, en} by exactly the datapath latency.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         for (int k = 0; k < int'(LATENCY); k++) begin
            r_sync[k] <= '0;
         end
      end else begin
         r_sync[0] <= {hsync, vsync, en};
         for (int k = 1; k < int'(LATENCY); k++) begin
            r_sync[k] <= r_sync[k-1];
         end
      end
   end

   assign o_hsync = r_sync[LATENCY-1][2];
   assign o_vsync = r_sync[LATENCY-1][1];
   assign o_en    = r_sync[LATENCY-1][0];

endmodule
